commit_arbiter: RTL and testbench

Write-back side of the execution-unit commit protocol. Each cycle it collects pending results from up to `N_UNITS` execution units (ALUs and peers) that raise `req`/`valid`. It grants one unit in round-robin order, pulses that unit's `clear` to retire the result, and drives a registered single-port register-file write. An error result raises a precise exception record and halts commit until the pipeline is flushed.

---
 rtl/core_config_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/commit_arbiter.sv | 149 ++++++++++++++
 tb/tb_commit_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// ============================================================================
// Module  : core_config_pkg
// Brief   : Core-wide configuration constants and shared commit-side types.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package core_config_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int N_EXEC_UNITS = 5;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } commit_state_t;

endpackage : core_config_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker: first set request at or above
//           ptr, wrapping modulo N. Shared by the commit and issue sides.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      // The !any guard keeps only the first hit in rotated priority order.
      if (en && !any && (j < N) && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        any       = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/commit_arbiter.sv
// ============================================================================
// Module  : commit_arbiter
// Brief   : Round-robin commit of execution-unit results into a registered
//           register-file write port, with precise exception and halt.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module commit_arbiter #(
  parameter int N_UNITS    = core_config_pkg::N_EXEC_UNITS,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_UNITS-1:0][XLEN-1:0]         unit_res,
  input  logic [N_UNITS-1:0][REG_ADDR_W-1:0]   unit_rd,
  input  logic [N_UNITS-1:0]                   unit_valid,
  input  logic [N_UNITS-1:0]                   unit_error,
  input  logic [N_UNITS-1:0]                   unit_req,
  output logic [N_UNITS-1:0]                   unit_clear,
  input  logic                                 wb_ready,
  output logic                                 wr_en,
  output logic [REG_ADDR_W-1:0]                wr_addr,
  output logic [XLEN-1:0]                      wr_data,
  output logic                                 exc_valid,
  output logic [$clog2(N_UNITS)-1:0]           exc_unit,
  output logic [REG_ADDR_W-1:0]                exc_rd,
  output logic                                 halted,
  input  logic                                 flush
);

  import core_config_pkg::*;

  localparam int UNIT_ID_W = $clog2(N_UNITS);

  commit_state_t         state_q,     state_d;
  logic [UNIT_ID_W-1:0]  ptr_q,       ptr_d;
  logic                  wr_en_q,     wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [XLEN-1:0]       wr_data_q,   wr_data_d;
  logic                  exc_valid_q, exc_valid_d;
  logic [UNIT_ID_W-1:0]  exc_unit_q,  exc_unit_d;
  logic [REG_ADDR_W-1:0] exc_rd_q,    exc_rd_d;

  logic [N_UNITS-1:0]    eligible;
  logic                  stage_free;
  logic                  arb_en;
  logic [N_UNITS-1:0]    grant;
  logic [UNIT_ID_W-1:0]  grant_idx;
  logic                  grant_any;
  logic                  grant_err;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic [XLEN-1:0]       grant_res;

  assign eligible   = unit_req & unit_valid;
  assign stage_free = !wr_en_q || wb_ready;

  rr_arbiter #(
    .N     (N_UNITS),
    .IDX_W (UNIT_ID_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign grant_err = unit_error[grant_idx];
  assign grant_rd  = unit_rd[grant_idx];
  assign grant_res = unit_res[grant_idx];

  // State register: all commit-side flops share one async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_unit_q  <= '0;
      exc_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      exc_valid_q <= exc_valid_d;
      exc_unit_q  <= exc_unit_d;
      exc_rd_q    <= exc_rd_d;
    end
  end

  // Next-state and registered-output datapath.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    exc_valid_d = 1'b0;
    exc_unit_d  = exc_unit_q;
    exc_rd_d    = exc_rd_q;

    if (flush) begin
      state_d = RUN;
      wr_en_d = 1'b0;
    end else begin
      if (stage_free) begin
        wr_en_d = 1'b0;
      end
      if (grant_any) begin
        ptr_d = (grant_idx == UNIT_ID_W'(N_UNITS - 1)) ? '0
                                                       : grant_idx + UNIT_ID_W'(1);
        if (grant_err) begin
          state_d     = HALT;
          exc_valid_d = 1'b1;
          exc_unit_d  = grant_idx;
          exc_rd_d    = grant_rd;
        end else if (grant_rd != '0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = grant_rd;
          wr_data_d = grant_res;
        end
      end
    end
  end

  // Grants are suppressed while in reset so no result is retired then.
  always_comb begin
    arb_en     = rst_n && (state_q == RUN) && stage_free && !flush;
    unit_clear = grant;
    halted     = (state_q == HALT);
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_unit  = exc_unit_q;
  assign exc_rd    = exc_rd_q;

endmodule : commit_arbiter

`default_nettype wire

// File: tb/tb_commit_arbiter.sv
// ============================================================================
// Module  : tb_commit_arbiter
// Brief   : Scenario bench for commit_arbiter with an expected-write queue.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_commit_arbiter;

  localparam int N  = 5;
  localparam int XW = 32;
  localparam int AW = 5;
  localparam int IW = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0][XW-1:0] unit_res;
  logic [N-1:0][AW-1:0] unit_rd;
  logic [N-1:0]         unit_valid, unit_error, unit_req, unit_clear;
  logic                 wb_ready, wr_en, exc_valid, halted, flush;
  logic [AW-1:0]        wr_addr, exc_rd;
  logic [XW-1:0]        wr_data;
  logic [IW-1:0]        exc_unit;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [XW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  commit_arbiter #(.N_UNITS(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .unit_res(unit_res), .unit_rd(unit_rd),
    .unit_valid(unit_valid), .unit_error(unit_error), .unit_req(unit_req),
    .unit_clear(unit_clear), .wb_ready(wb_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .exc_valid(exc_valid),
    .exc_unit(exc_unit), .exc_rd(exc_rd), .halted(halted), .flush(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    unit_res = '0; unit_rd = '0; unit_valid = '0; unit_error = '0;
    unit_req = '0; wb_ready = 1'b1; flush = 1'b0; rst_n = 1'b0;
    #12;
    total++;
    if ({unit_clear, wr_en, wr_addr, wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_wr: got clear=%b en=%b addr=%0d data=%h want all 0",
               unit_clear, wr_en, wr_addr, wr_data);
    end
    total++;
    if ({exc_valid, exc_unit, exc_rd, halted} !== '0) begin
      bad++;
      $display("FAIL reset_exc: got v=%b unit=%0d rd=%0d halted=%b want all 0",
               exc_valid, exc_unit, exc_rd, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    unit_req[0] = 1'b1;  // requesting but not valid: must be ignored
    unit_res[2] = 32'hDEADBEEF; unit_rd[2] = 5'd5;
    unit_valid[2] = 1'b1; unit_req[2] = 1'b1;
    #1;
    total++;
    if (unit_clear !== 5'b00100) begin
      bad++; $display("FAIL single_clear: got %b want 00100", unit_clear);
    end
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    tick();
    unit_req = '0; unit_valid = '0;
    total++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL single_wr_en: got %b want 1", wr_en);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (wr_addr !== e.addr || wr_data !== e.data) begin
        bad++; $display("FAIL single_wr: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
      end
    end
    total++;
    if (dut.ptr_q !== 3'd3) begin
      bad++; $display("FAIL single_ptr: got %0d want 3", dut.ptr_q);
    end
    tick();
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL single_wr_done: got %b want 0", wr_en);
    end
  endtask

  task automatic test_error_flush();
    unit_res[0] = 32'hA0A0_0000; unit_rd[0] = 5'd1;
    unit_res[3] = 32'h3333_3333; unit_rd[3] = 5'd7; unit_error[3] = 1'b1;
    unit_res[4] = 32'h4444_0004; unit_rd[4] = 5'd20;
    unit_valid = 5'b11001; unit_req = 5'b11001;
    #1;
    total++;
    if (unit_clear !== 5'b01000) begin
      bad++; $display("FAIL err_clear: got %b want 01000", unit_clear);
    end
    tick();
    unit_req[3] = 1'b0; unit_valid[3] = 1'b0; unit_error[3] = 1'b0;
    #1;
    total++;
    if ({exc_valid, exc_unit, exc_rd} !== {1'b1, 3'd3, 5'd7}) begin
      bad++; $display("FAIL err_exc: got v=%b unit=%0d rd=%0d want 1/3/7", exc_valid, exc_unit, exc_rd);
    end
    total++;
    if (halted !== 1'b1 || wr_en !== 1'b0 || unit_clear !== 5'b00000) begin
      bad++; $display("FAIL err_halt: got halted=%b en=%b clear=%b want 1/0/00000", halted, wr_en, unit_clear);
    end
    tick();
    total++;
    if (exc_valid !== 1'b0 || halted !== 1'b1 || unit_clear !== 5'b00000) begin
      bad++; $display("FAIL err_hold: got v=%b halted=%b clear=%b want 0/1/00000", exc_valid, halted, unit_clear);
    end
    flush = 1'b1;
    #1;
    total++;
    if (unit_clear !== 5'b00000) begin
      bad++; $display("FAIL flush_cycle_clear: got %b want 00000", unit_clear);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0 || unit_clear !== 5'b10000) begin
      bad++; $display("FAIL flush_resume: got halted=%b clear=%b want 0/10000", halted, unit_clear);
    end
    exp_q.push_back('{addr: 5'd20, data: 32'h4444_0004});
    tick();
    unit_req = '0; unit_valid = '0;
    total++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL flush_wr_en: got %b want 1", wr_en);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (wr_addr !== e.addr || wr_data !== e.data) begin
        bad++; $display("FAIL flush_wr: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
      end
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_oh;
    for (int i = 0; i < N; i++) begin
      unit_res[i] = 32'h1000_0000 + 32'(i);
      unit_rd[i]  = AW'(10 + i);
    end
    unit_valid = '1; unit_req = '1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_oh = '0;
      exp_oh[k % N] = 1'b1;
      total++;
      if (unit_clear !== exp_oh) begin
        bad++; $display("FAIL fair_clear[%0d]: got %b want %b", k, unit_clear, exp_oh);
      end
      exp_q.push_back('{addr: AW'(10 + (k % N)), data: 32'h1000_0000 + 32'(k % N)});
      tick();
      if (k == 5) begin
        unit_req = '0; unit_valid = '0;
      end
      total++;
      if (wr_en !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL fair_wr_en[%0d]: got %b want 1", k, wr_en);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          bad++; $display("FAIL fair_wr[%0d]: got %0d/%h want %0d/%h", k, wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    unit_res[1] = 32'hCAFE_0001; unit_rd[1] = 5'd9;
    unit_valid[1] = 1'b1; unit_req[1] = 1'b1;
    #1;
    total++;
    if (unit_clear !== 5'b00010) begin
      bad++; $display("FAIL bp_first_clear: got %b want 00010", unit_clear);
    end
    exp_q.push_back('{addr: 5'd9, data: 32'hCAFE_0001});
    tick();
    unit_req[1] = 1'b0; unit_valid[1] = 1'b0;
    wb_ready = 1'b0;
    unit_res[3] = 32'hB0B0_0003; unit_rd[3] = 5'd12;
    unit_valid[3] = 1'b1; unit_req[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (unit_clear !== 5'b00000) begin
        bad++; $display("FAIL bp_clear[%0d]: got %b want 00000", c, unit_clear);
      end
      total++;
      if (exp_q.size() == 0 || wr_en !== 1'b1 || wr_addr !== exp_q[0].addr || wr_data !== exp_q[0].data) begin
        bad++; $display("FAIL bp_hold[%0d]: got %b/%0d/%h want 1/9/cafe0001", c, wr_en, wr_addr, wr_data);
      end
      tick();
    end
    wb_ready = 1'b1;
    #1;
    total++;
    if (unit_clear !== 5'b01000) begin
      bad++; $display("FAIL bp_resume_clear: got %b want 01000", unit_clear);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_q.push_back('{addr: 5'd12, data: 32'hB0B0_0003});
    tick();
    unit_req = '0; unit_valid = '0;
    total++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL bp_wr_en: got %b want 1", wr_en);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (wr_addr !== e.addr || wr_data !== e.data) begin
        bad++; $display("FAIL bp_wr: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
      end
    end
    tick();
  endtask

  task automatic test_x0_write();
    unit_res[1] = 32'h0BAD_0BAD; unit_rd[1] = 5'd0;
    unit_valid[1] = 1'b1; unit_req[1] = 1'b1;
    #1;
    total++;
    if (unit_clear !== 5'b00010) begin
      bad++; $display("FAIL x0_clear: got %b want 00010", unit_clear);
    end
    tick();
    unit_req = '0; unit_valid = '0;
    total++;
    if (wr_en !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL x0_wr_en: got %b want 0", wr_en);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    unit_res[2] = 32'h5555_AAAA; unit_rd[2] = 5'd3;
    unit_valid[2] = 1'b1; unit_req[2] = 1'b1;
    #1;
    exp_q.push_back('{addr: 5'd3, data: 32'h5555_AAAA});
    tick();
    unit_req = '0; unit_valid = '0;
    total++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL mid_wr_en: got %b want 1", wr_en);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (wr_addr !== e.addr || wr_data !== e.data) begin
        bad++; $display("FAIL mid_wr: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({unit_clear, wr_en, wr_addr, wr_data, exc_valid, exc_unit, exc_rd, halted} !== '0) begin
      bad++; $display("FAIL mid_async_reset: got en=%b addr=%0d data=%h want 0/0/0", wr_en, wr_addr, wr_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    unit_res = '0; unit_rd = '0;
    for (int i = 0; i < N; i++) unit_rd[i] = AW'(i + 1);
    unit_valid = '1; unit_req = '1;
    #1;
    total++;
    if (unit_clear !== 5'b00001) begin
      bad++; $display("FAIL mid_first_grant: got %b want 00001", unit_clear);
    end
    tick();
    unit_req = '0; unit_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_error_flush();
    test_fairness();
    test_backpressure();
    test_x0_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_commit_arbiter

`default_nettype wire
